// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: core sequencing states
// and the owner tag that steers registered read data back to its requester.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } rd_owner_e;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Only reads produce a return beat; a granted data write leaves nothing pending.
  function automatic rd_owner_e next_owner(input logic d_gnt, input logic d_we,
                                           input logic i_gnt);
    rd_owner_e owner;
    owner = NONE;
    if (i_gnt) begin
      owner = FETCH;
    end else if (d_gnt && !d_we) begin
      owner = DATA;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_fetch_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port was kept waiting;
// sat_o tells the arbiter to let fetch win over data.
module fetch_starve_ctr #(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for loader, load/store and fetch, which also
// sequences the core through LOAD -> RUN -> HALT.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  input  logic              ld_done,
  input  logic              halt_req,
  output logic              core_run,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_e state_q;
  rd_owner_e  rd_owner_q;
  rd_owner_e  rd_owner_d;
  logic       core_run_q;
  logic       starve_sat;
  logic       starve_inc;

  // Byte offsets within a word never reach the word-addressed memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ld_addr[1:0], d_addr[1:0], i_addr[1:0]};

  always_comb begin
    ld_gnt    = 1'b0;
    d_gnt     = 1'b0;
    i_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      LOAD: begin
        if (ld_req) begin
          ld_gnt    = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_be    = BE_FULL;
          mem_addr  = ld_addr[ADDR_W-1:2];
          mem_wdata = ld_wdata;
        end
      end
      RUN: begin
        // Data normally wins; a fetch starved long enough takes the slot.
        if (i_req && (starve_sat || !d_req)) begin
          i_gnt    = 1'b1;
          mem_en   = 1'b1;
          mem_be   = BE_FULL;
          mem_addr = i_addr[ADDR_W-1:2];
        end else if (d_req) begin
          d_gnt     = 1'b1;
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_be    = d_be;
          mem_addr  = d_addr[ADDR_W-1:2];
          mem_wdata = d_wdata;
        end
      end
      default: begin
      end
    endcase
  end

  assign starve_inc = (state_q == RUN) && i_req && !i_gnt;

  fetch_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc_i(starve_inc),
    .clr_i(!starve_inc),
    .sat_o(starve_sat)
  );

  assign rd_owner_d = next_owner(d_gnt, d_we, i_gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      core_run_q <= 1'b0;
      rd_owner_q <= NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
      case (state_q)
        LOAD: begin
          if (ld_done) begin
            state_q    <= RUN;
            core_run_q <= 1'b1;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_q    <= HALT;
            core_run_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= HALT;
          core_run_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_run = core_run_q;
  assign d_rvalid = (rd_owner_q == DATA);
  assign i_rvalid = (rd_owner_q == FETCH);
  assign d_rdata  = mem_rdata;
  assign i_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory
// behind the shared port.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 18;

  logic              clk;
  logic              rst;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_done;
  logic              halt_req;
  logic              core_run;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_model [0:(1<<(ADDR_W-2))-1];
  logic [31:0] img [4];

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_done(ld_done), .halt_req(halt_req), .core_run(core_run),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    img[0] = 32'hA000_0013;
    img[1] = 32'hB000_0013;
    img[2] = 32'h0000_0013;
    img[3] = 32'hD000_0013;
    rst = 1'b0; ld_req = 0; ld_addr = '0; ld_wdata = '0; ld_done = 0; halt_req = 0;
    d_req = 0; d_we = 0; d_be = 4'hF; d_addr = '0; d_wdata = '0; i_req = 0; i_addr = '0;
    #2;
    check("rst_core_run", 32'(core_run), 0);
    check("rst_d_rvalid", 32'(d_rvalid), 0);
    check("rst_i_rvalid", 32'(i_rvalid), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    step(); step();
    rst = 1'b1;

    // image load with competing data request; ld_done rides on the last write
    d_req = 1;
    for (int k = 0; k < 4; k++) begin
      ld_req = 1; ld_addr = ADDR_W'(k * 4); ld_wdata = img[k]; ld_done = (k == 3);
      #2;
      check("load_ld_gnt", 32'(ld_gnt), 1);
      check("load_d_gnt", 32'(d_gnt), 0);
      check("load_core_run", 32'(core_run), 0);
      check("load_mem_addr", 32'(mem_addr), k);
      check("load_mem_be", 32'(mem_be), 32'hF);
      step();
    end
    ld_done = 0; d_req = 0;
    #2;
    check("run_core_run", 32'(core_run), 1);
    check("run_ld_gnt", 32'(ld_gnt), 0);
    check("run_mem_en_idle", 32'(mem_en), 0);

    // fetch read
    step(); ld_req = 0; i_req = 1; i_addr = 18'h8;
    #2;
    check("fetch_i_gnt", 32'(i_gnt), 1);
    check("fetch_mem_addr", 32'(mem_addr), 2);
    check("fetch_mem_we", 32'(mem_we), 0);
    check("fetch_mem_be", 32'(mem_be), 32'hF);
    step(); i_req = 0;
    #2;
    check("fetch_i_rvalid", 32'(i_rvalid), 1);
    check("fetch_i_rdata", i_rdata, 32'h0000_0013);
    check("fetch_d_rvalid", 32'(d_rvalid), 0);

    // conflict: data wins, fetch follows, returns in grant order
    step(); d_req = 1; d_addr = 18'h4; i_req = 1; i_addr = 18'h0;
    #2;
    check("conf_d_gnt", 32'(d_gnt), 1);
    check("conf_i_gnt", 32'(i_gnt), 0);
    check("conf_mem_addr", 32'(mem_addr), 1);
    step(); d_req = 0;
    #2;
    check("conf2_i_gnt", 32'(i_gnt), 1);
    check("conf2_d_rvalid", 32'(d_rvalid), 1);
    check("conf2_d_rdata", d_rdata, 32'hB000_0013);
    check("conf2_i_rvalid", 32'(i_rvalid), 0);
    step(); i_req = 0;
    #2;
    check("conf3_i_rvalid", 32'(i_rvalid), 1);
    check("conf3_i_rdata", i_rdata, 32'hA000_0013);
    check("conf3_d_rvalid", 32'(d_rvalid), 0);

    // starvation: four data wins, fetch takes the fifth cycle
    step(); d_req = 1; d_addr = 18'hC; i_req = 1; i_addr = 18'h4;
    for (int c = 1; c <= 4; c++) begin
      #2;
      check("starve_d_gnt", 32'(d_gnt), 1);
      check("starve_i_gnt", 32'(i_gnt), 0);
      if (c > 1) check("starve_d_rdata", d_rdata, 32'hD000_0013);
      step();
    end
    #2;
    check("starve5_i_gnt", 32'(i_gnt), 1);
    check("starve5_d_gnt", 32'(d_gnt), 0);
    check("starve5_mem_addr", 32'(mem_addr), 1);
    step();
    #2;
    check("starve6_d_gnt", 32'(d_gnt), 1);
    check("starve6_i_gnt", 32'(i_gnt), 0);
    check("starve6_i_rvalid", 32'(i_rvalid), 1);
    check("starve6_i_rdata", i_rdata, 32'hB000_0013);
    step(); d_req = 0; i_req = 0;
    #2;
    check("starve7_d_rvalid", 32'(d_rvalid), 1);

    // partial data write, then read back the merged word
    step(); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 18'h6; d_wdata = 32'h1234_BEEF;
    #2;
    check("wr_d_gnt", 32'(d_gnt), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_be", 32'(mem_be), 32'h3);
    check("wr_mem_addr", 32'(mem_addr), 1);
    check("wr_mem_wdata", mem_wdata, 32'h1234_BEEF);
    step(); d_req = 0; d_we = 0; d_be = 4'hF;
    #2;
    check("wr_no_d_rvalid", 32'(d_rvalid), 0);
    check("wr_no_i_rvalid", 32'(i_rvalid), 0);
    step(); d_req = 1; d_addr = 18'h4;
    #2;
    check("rb_d_gnt", 32'(d_gnt), 1);
    step(); d_req = 0;
    #2;
    check("rb_d_rvalid", 32'(d_rvalid), 1);
    check("rb_d_rdata", d_rdata, 32'hB000_BEEF);

    // halt with a same-cycle data read
    step(); halt_req = 1; d_req = 1; d_addr = 18'h0;
    #2;
    check("halt_d_gnt", 32'(d_gnt), 1);
    check("halt_core_run_pre", 32'(core_run), 1);
    step(); halt_req = 0; i_req = 1; ld_req = 1; ld_addr = 18'h20;
    #2;
    check("halt_core_run", 32'(core_run), 0);
    check("halt_d_gnt0", 32'(d_gnt), 0);
    check("halt_i_gnt0", 32'(i_gnt), 0);
    check("halt_ld_gnt0", 32'(ld_gnt), 0);
    check("halt_mem_en", 32'(mem_en), 0);
    check("halt_d_rvalid", 32'(d_rvalid), 1);
    check("halt_d_rdata", d_rdata, 32'hA000_0013);
    step(); ld_done = 1;
    #2;
    check("halt2_d_gnt", 32'(d_gnt), 0);
    check("halt2_d_rvalid", 32'(d_rvalid), 0);
    step(); ld_done = 0;
    #2;
    check("halt3_core_run", 32'(core_run), 0);
    check("halt3_i_gnt", 32'(i_gnt), 0);

    // reset back to LOAD; halt_req in LOAD is ignored
    step(); d_req = 0; i_req = 0; ld_req = 0; rst = 0;
    #2;
    check("rst2_core_run", 32'(core_run), 0);
    step(); rst = 1; ld_done = 1; halt_req = 1;
    #2;
    check("rst2_load_core_run", 32'(core_run), 0);
    step(); ld_done = 0; halt_req = 0; i_req = 1; i_addr = 18'h8;
    #2;
    check("rst2_run_core_run", 32'(core_run), 1);
    check("rst2_i_gnt", 32'(i_gnt), 1);
    #1; rst = 0;
    step(); i_req = 0;
    #2;
    check("rstmid_i_rvalid", 32'(i_rvalid), 0);
    check("rstmid_d_rvalid", 32'(d_rvalid), 0);
    check("rstmid_core_run", 32'(core_run), 0);
    step(); rst = 1; ld_req = 1; ld_addr = 18'h10; ld_wdata = 32'h0; d_req = 1;
    #2;
    check("rstpost_i_rvalid", 32'(i_rvalid), 0);
    check("rstpost_ld_gnt", 32'(ld_gnt), 1);
    check("rstpost_d_gnt", 32'(d_gnt), 0);
    step(); ld_req = 0; d_req = 0;
    #2;
    check("rstpost_d_rvalid", 32'(d_rvalid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
